// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The master drives start/a/b; the slave (the subtractor) drives busy/done/diff/bout.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first WIDTH-bit subtractor with start/busy/done handshake.
// Define APPROX_LSB_EN to compute the low APPROX_BITS positions borrow-free.
module serial_subtractor #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Refuses to elaborate with an out-of-range configuration.
  if (WIDTH < 2 || APPROX_BITS < 0 || APPROX_BITS >= WIDTH) begin : g_bad_params
    serial_subtractor_illegal_parameters u_bad ();
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic bitA, bitB, dBit, brNext;

  assign bitA = aSh_q[0];
  assign bitB = bSh_q[0];

  // One full-subtractor step on the current LSBs against the borrow register.
  always_comb begin
    dBit   = bitA ^ bitB ^ br_q;
    brNext = (~bitA & bitB) | (~(bitA ^ bitB) & br_q);
`ifdef APPROX_LSB_EN
    if (cnt_q < CW'(APPROX_BITS)) begin
      dBit   = bitA ^ bitB;
      brNext = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Result bits enter at the MSB so bit i lands at position i after WIDTH steps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          aSh_d   = bus.a;
          bSh_d   = bus.b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        res_d = {dBit, res_q[WIDTH-1:1]};
        br_d  = brNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = {dBit, res_q[WIDTH-1:1]};
          bout_d  = brNext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule
